// File: rtl/complex_pkg.sv
// Shared constants and helpers for the complex add/sub datapath.
// Helpers work on MAX_W-wide containers so any W up to MAX_W can share them.
package complex_pkg;

  localparam int MAX_W  = 64;
  localparam int OVF_RE = 1;
  localparam int OVF_IM = 0;

  function automatic logic [MAX_W-1:0] low_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_pos(input int unsigned w);
    return low_mask(w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] re_of(input logic [2*MAX_W-1:0] c, input int unsigned w);
    logic [2*MAX_W-1:0] t;
    t = c >> w;
    return t[MAX_W-1:0] & low_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] im_of(input logic [2*MAX_W-1:0] c, input int unsigned w);
    return c[MAX_W-1:0] & low_mask(w);
  endfunction

  function automatic logic [2*MAX_W-1:0] pack_c(input logic [MAX_W-1:0] re,
                                                input logic [MAX_W-1:0] im,
                                                input int unsigned w);
    logic [2*MAX_W-1:0] t;
    t = {{MAX_W{1'b0}}, re & low_mask(w)} << w;
    return t | {{MAX_W{1'b0}}, im & low_mask(w)};
  endfunction

endpackage

// File: rtl/complex_addsub_lane.sv
// One component lane: signed add/sub on W+1 bits, optional halving,
// then saturate or wrap with an overflow flag. Purely combinational.
module complex_addsub_lane
  import complex_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         scale,
  input  logic         sat,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] sum;

  assign a_ext = {a[W-1], a};
  assign b_ext = {b[W-1], b};
  assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

  always_comb begin
    y   = sum[W-1:0];
    ovf = 1'b0;
    if (scale) begin
      // halving a W+1 bit result always fits, so no overflow is possible
      y = sum[W:1];
    end else if (sum[W] != sum[W-1]) begin
      ovf = 1'b1;
      if (sat) y = sum[W] ? W'(sat_neg(W)) : W'(sat_pos(W));
    end
  end

endmodule

// File: rtl/complex_addsub_pipe.sv
// Two-stage valid/ready complex add/sub: S1 holds operands, S2 holds results,
// plus a saturating counter of delivered results that overflowed.
module complex_addsub_pipe
  import complex_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2*W-1:0]   A,
  input  logic [2*W-1:0]   B,
  input  logic             SUB,
  input  logic             SCALE,
  input  logic             SAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [2*W-1:0]   R,
  output logic [1:0]       OVF,
  input  logic             CLR_CNT,
  output logic [CNT_W-1:0] OVF_CNT
);

  logic           s1_valid;
  logic [2*W-1:0] s1_a;
  logic [2*W-1:0] s1_b;
  logic           s1_sub;
  logic           s1_scale;
  logic           s1_sat;

  logic           s2_accept;
  logic           s1_accept;
  logic           out_xfer;

  logic [W-1:0]   re_y;
  logic [W-1:0]   im_y;
  logic           re_ovf;
  logic           im_ovf;

  assign s2_accept = !OUT_VALID || OUT_READY;
  assign s1_accept = !s1_valid || s2_accept;
  assign IN_READY  = s1_accept;
  assign out_xfer  = OUT_VALID && OUT_READY;

  complex_addsub_lane #(.W(W)) u_lane_re (
    .a     (W'(re_of((2*MAX_W)'(s1_a), W))),
    .b     (W'(re_of((2*MAX_W)'(s1_b), W))),
    .sub   (s1_sub),
    .scale (s1_scale),
    .sat   (s1_sat),
    .y     (re_y),
    .ovf   (re_ovf)
  );

  complex_addsub_lane #(.W(W)) u_lane_im (
    .a     (W'(im_of((2*MAX_W)'(s1_a), W))),
    .b     (W'(im_of((2*MAX_W)'(s1_b), W))),
    .sub   (s1_sub),
    .scale (s1_scale),
    .sat   (s1_sat),
    .y     (im_y),
    .ovf   (im_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sub    <= 1'b0;
      s1_scale  <= 1'b0;
      s1_sat    <= 1'b0;
      OUT_VALID <= 1'b0;
      R         <= '0;
      OVF       <= '0;
    end else begin
      if (s2_accept) begin
        OUT_VALID <= s1_valid;
        if (s1_valid) begin
          R           <= (2*W)'(pack_c(MAX_W'(re_y), MAX_W'(im_y), W));
          OVF[OVF_RE] <= re_ovf;
          OVF[OVF_IM] <= im_ovf;
        end
      end
      if (s1_accept) begin
        s1_valid <= IN_VALID;
        if (IN_VALID) begin
          s1_a     <= A;
          s1_b     <= B;
          s1_sub   <= SUB;
          s1_scale <= SCALE;
          s1_sat   <= SAT;
        end
      end
    end
  end

  // clear has priority over counting; count sticks at all-ones
  always_ff @(posedge CLK) begin
    if (RST || CLR_CNT) begin
      OVF_CNT <= '0;
    end else if (out_xfer && (OVF != 2'b00) && (OVF_CNT != {CNT_W{1'b1}})) begin
      OVF_CNT <= OVF_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Self-checking bench: integer reference model and scoreboard queue; a second
// instance with a 2-bit counter exercises counter saturation.
module tb_complex_addsub_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        SUB = 1'b0;
  logic        SCALE = 1'b0;
  logic        SAT = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] R;
  logic [1:0]  OVF;
  logic        CLR_CNT = 1'b0;
  logic [15:0] OVF_CNT;

  logic        in_ready2, out_valid2;
  logic [31:0] r2;
  logic [1:0]  ovf2;
  logic [1:0]  cnt2;

  complex_addsub_pipe #(.W(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .SUB(SUB), .SCALE(SCALE), .SAT(SAT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .R(R), .OVF(OVF),
    .CLR_CNT(CLR_CNT), .OVF_CNT(OVF_CNT)
  );

  complex_addsub_pipe #(.W(16), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
    .A(A), .B(B), .SUB(SUB), .SCALE(SCALE), .SAT(SAT),
    .OUT_VALID(out_valid2), .OUT_READY(OUT_READY), .R(r2), .OVF(ovf2),
    .CLR_CNT(CLR_CNT), .OVF_CNT(cnt2)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [33:0] q[$];
  int cnt_m = 0;
  int cnt2_m = 0;
  bit stalled_prev = 0;
  logic [31:0] prev_r;
  logic [1:0]  prev_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sub, input bit scale, input bit sat);
    logic [31:0] r;
    logic [1:0]  o;
    for (int k = 0; k < 2; k++) begin
      int xa, xb, s, y;
      xa = int'($signed(a[k*16 +: 16]));
      xb = int'($signed(b[k*16 +: 16]));
      s  = sub ? xa - xb : xa + xb;
      o[k] = 1'b0;
      if (scale) y = s >>> 1;
      else if (s > 32767 || s < -32768) begin
        o[k] = 1'b1;
        y = sat ? ((s > 0) ? 32767 : -32768) : s;
      end else y = s;
      r[k*16 +: 16] = 16'(y);
    end
    return {o, r};
  endfunction

  task automatic step();
    logic [33:0] e;
    @(negedge CLK);
    if (!RST) begin
      chk("in_ready", IN_READY, (OUT_READY || q.size() < 2));
      chk("ovf_cnt", OVF_CNT, cnt_m);
      chk("ovf_cnt_small", cnt2, cnt2_m);
      if (stalled_prev) begin
        chk("stall_r_stable", R, prev_r);
        chk("stall_ovf_stable", OVF, prev_ovf);
      end
    end
    if (RST) begin
      q.delete();
      cnt_m = 0; cnt2_m = 0; stalled_prev = 0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("r", R, e[31:0]);
          chk("ovf", OVF, e[33:32]);
          if (!CLR_CNT && e[33:32] != 2'b00) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
          end
        end
      end
      if (CLR_CNT) begin cnt_m = 0; cnt2_m = 0; end
      if (IN_VALID && IN_READY) q.push_back(model(A, B, SUB, SCALE, SAT));
      stalled_prev = OUT_VALID && !OUT_READY;
      prev_r = R; prev_ovf = OVF;
    end
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input bit sub, input bit scale, input bit sat);
    bit acc;
    bit done = 0;
    A = a; B = b; SUB = sub; SCALE = scale; SAT = sat; IN_VALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = IN_READY;
      step();
      done = acc;
    end
    if (!done) chk("send_timeout", done, 1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
    step(); step();
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] edges[5];
    edges = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
    if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    int n;
    bit saw_low;
    bit acc;
    step(); step();
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_r", R, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_cnt", OVF_CNT, 0);
    chk("rst_in_ready", IN_READY, 1);
    RST = 1'b0;

    // first cycle out of reset, directed corner vectors
    A = 32'h7FFF_0000; B = 32'h0001_0000; SAT = 1; IN_VALID = 1;
    chk("first_in_ready", IN_READY, 1);
    send(32'h7FFF_0000, 32'h0001_0000, 0, 0, 1);
    send(32'h7FFF_0000, 32'h0001_0000, 0, 0, 0);
    send(32'h0003_8000, 32'h0002_0001, 1, 0, 1);
    send(32'h7FFF_FFFF, 32'h0001_FFFF, 0, 1, 1);
    send(32'h0001_0001, 32'h0000_0000, 0, 1, 0);
    drain();

    // latency: result appears exactly two cycles after the input transfer
    send(32'h1234_5678, 32'h1111_2222, 0, 0, 0);
    chk("latency_c1", OUT_VALID, 0);
    step();
    chk("latency_c2", OUT_VALID, 1);
    drain();

    // 8 back-to-back with downstream stall in cycles 3..5
    n = 0; saw_low = 0;
    A = {pick(), pick()}; B = {pick(), pick()};
    SUB = 1'($urandom); SCALE = 0; SAT = 1'($urandom); IN_VALID = 1;
    for (int c = 0; c < 30 && n < 8; c++) begin
      OUT_READY = !(c >= 3 && c <= 5);
      if (!IN_READY) saw_low = 1;
      acc = IN_READY;
      step();
      if (acc) begin
        n++;
        A = {pick(), pick()}; B = {pick(), pick()};
        SUB = 1'($urandom); SAT = 1'($urandom);
      end
    end
    IN_VALID = 0;
    chk("stream_count", n, 8);
    chk("stream_in_ready_low", saw_low, 1);
    drain();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      IN_VALID = ($urandom_range(0, 9) < 7);
      OUT_READY = ($urandom_range(0, 9) < 7);
      CLR_CNT = ($urandom_range(0, 99) < 3);
      A = {pick(), pick()}; B = {pick(), pick()};
      SUB = 1'($urandom); SCALE = 1'($urandom); SAT = 1'($urandom);
      step();
    end
    CLR_CNT = 0;
    drain();

    // overflow counter
    CLR_CNT = 1; step(); CLR_CNT = 0;
    for (int i = 0; i < 3; i++) send(32'h7FFF_0000, 32'h0001_0000, 0, 0, 0);
    send(32'h0003_0004, 32'h0002_0001, 1, 0, 0);
    drain();
    chk("cnt_three", OVF_CNT, 3);
    send(32'h8000_0000, 32'h0001_0000, 1, 0, 1);
    for (int i = 0; i < 10 && !OUT_VALID; i++) step();
    chk("clr_wait_valid", OUT_VALID, 1);
    CLR_CNT = 1; step(); CLR_CNT = 0;
    chk("cnt_clr_wins", OVF_CNT, 0);
    chk("cnt_small_clr", cnt2, 0);
    for (int i = 0; i < 4; i++) send(32'h0000_7FFF, 32'h0000_7FFF, 0, 0, 1);
    drain();
    chk("cnt_small_sat", cnt2, 3);
    chk("cnt_four", OVF_CNT, 4);

    // reset with both stages full
    OUT_READY = 0; IN_VALID = 1;
    A = 32'h0102_0304; B = 32'h0506_0708;
    for (int i = 0; i < 10 && q.size() < 2; i++) step();
    chk("full_before_rst", q.size(), 2);
    IN_VALID = 0; RST = 1;
    step();
    RST = 0;
    chk("post_rst_out_valid", OUT_VALID, 0);
    chk("post_rst_in_ready", IN_READY, 1);
    OUT_READY = 1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_cnt", OVF_CNT, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/complex_addsub_pipe.md
COMPLEX_ADDSUB_PIPE -- requirements
Module: complex_addsub_pipe

Interface
REQ-001 The block SHALL take parameter W, default 16, as the width of each real and each imaginary component.
REQ-002 The block SHALL take parameter CNT_W, default 16, as the width of the overflow event counter.
REQ-003 Port CLK, input, 1 bit: the only clock; every register updates on its rising edge.
REQ-004 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port IN_VALID, input, 1 bit: an operand pair is present on A and B.
REQ-006 Port IN_READY, output, 1 bit: the block accepts the pair in this cycle.
REQ-007 Port A, input, 2W bits: real part in A[2W-1:W], imaginary part in A[W-1:0], signed two's complement.
REQ-008 Port B, input, 2W bits: same packing as A.
REQ-009 Port SUB, input, 1 bit: 0 gives A+B, 1 gives A-B; captured with the operands.
REQ-010 Port SCALE, input, 1 bit: when 1, each component result is divided by 2; captured with the operands.
REQ-011 Port SAT, input, 1 bit: when 1, overflow saturates; when 0, overflow wraps; captured with the operands.
REQ-012 Port OUT_VALID, output, 1 bit: R and OVF hold a result.
REQ-013 Port OUT_READY, input, 1 bit: the downstream block accepts the result.
REQ-014 Port R, output, 2W bits: result, packed the same way as A.
REQ-015 Port OVF, output, 2 bits: {real overflow, imaginary overflow}, valid together with R.
REQ-016 Port CLR_CNT, input, 1 bit: synchronous clear of OVF_CNT.
REQ-017 Port OVF_CNT, output, CNT_W bits: count of delivered results with any OVF bit set.

Function
REQ-018 A transfer SHALL occur on IN_VALID && IN_READY at the input and on OUT_VALID && OUT_READY at the output.
REQ-019 The pipeline SHALL have two register stages: S1 holds the operands and mode bits; S2 holds R and OVF.
REQ-020 With OUT_READY held high, latency from input transfer to OUT_VALID SHALL be 2 cycles, at a throughput of 1 transfer per cycle.
REQ-021 Ready logic: S2 SHALL accept when it is empty or OUT_READY=1; S1 SHALL accept when it is empty or S2 accepts; IN_READY SHALL equal S1 accept.
REQ-022 IN_READY SHALL be combinational and depend on no input other than OUT_READY.
REQ-023 While OUT_VALID=1 and OUT_READY=0, R and OVF SHALL hold stable.
REQ-024 No transaction SHALL be dropped or duplicated, and results SHALL leave in the order the operands arrived.
REQ-025 Each component SHALL be computed as a (W+1)-bit sign-extended sum or difference.
REQ-026 When SCALE=1, the result SHALL be bits [W:1] of the (W+1)-bit value (arithmetic shift, rounds toward minus infinity), and that component's OVF bit SHALL be 0.
REQ-027 When SCALE=0, a component SHALL overflow exactly when bit W differs from bit W-1.
REQ-028 On overflow with SAT=1, the component result SHALL be +max (0x7FFF at W=16) when bit W=0, and -min (0x8000 at W=16) when bit W=1.
REQ-029 On overflow with SAT=0, the component result SHALL be bits [W-1:0] of the (W+1)-bit value (wrap).
REQ-030 The OVF bit SHALL be 1 on overflow regardless of SAT.
REQ-031 OVF_CNT SHALL increment by 1 on each output transfer where OVF is not 0, and SHALL stop at its maximum value instead of wrapping.
REQ-032 When CLR_CNT and a counting transfer occur in the same cycle, OVF_CNT SHALL become 0; clear wins.

Reset
REQ-033 While RST=1, S1 and S2 SHALL be empty and OUT_VALID=0, R=0, OVF=0, OVF_CNT=0.
REQ-034 While RST=1, IN_READY SHALL be 1.
REQ-035 Reset asserted mid-stream SHALL discard all in-flight transactions without emitting them.
REQ-036 The first input transfer after reset SHALL be accepted in the first cycle with RST=0.

Structure
REQ-037 The W-dependent saturation limits, the OVF bit indices (1 = real, 0 = imaginary) and the packing helpers SHALL live in shared package complex_pkg.
REQ-038 One sub-module, complex_addsub_lane (one component: add/sub, scale, saturate, overflow flag), SHALL be instantiated twice; the lane SHALL be combinational and feed the S2 registers.

Verification
REQ-039 W=16, A.re=0x7FFF, B.re=0x0001, SUB=0, SCALE=0, SAT=1 -> R.re=0x7FFF, OVF[1]=1; the same with SAT=0 -> R.re=0x8000, OVF[1]=1.
REQ-040 A.im=0x8000, B.im=0x0001, SUB=1, SAT=1 -> R.im=0x8000, OVF[0]=1; A.re=0x0003, B.re=0x0002, SUB=1 -> R.re=0x0001, OVF[1]=0.
REQ-041 SCALE=1: 0x7FFF+0x0001 -> 0x4000; 0xFFFF+0xFFFF -> 0xFFFF; 0x0001+0x0000 -> 0x0000; OVF=0 in all three cases.
REQ-042 Stream 8 back-to-back pairs with OUT_READY=0 for cycles 3-5 -> IN_READY low while both stages are full, all 8 results delivered in order, R stable during the stall.
REQ-043 Send 3 overflowing results and 1 clean result -> OVF_CNT=3; CLR_CNT pulsed together with a 4th overflowing transfer -> OVF_CNT=0; forcing OVF_CNT to its maximum and sending 1 more overflow -> OVF_CNT stays at maximum.
REQ-044 Assert RST for 1 cycle with both stages full -> next cycle OUT_VALID=0, IN_READY=1, and no stale result is ever emitted.
